// File: rtl/writer_pkg.sv
// Shared types and defaults for the chip I/O handshake blocks.
// The input-side block owns interface_state_t; the output-side writer owns writer_state_t.
package writer_pkg;

  localparam int WRITER_DATA_W      = 8;
  localparam int WRITER_DEPTH       = 2;
  localparam int WRITER_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_WAIT_DATA,
    IF_ACK,
    IF_RELEASE
  } interface_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ,
    RELEASE
  } writer_state_t;

endpackage

// File: rtl/writer_fifo.sv
// Circular byte buffer for the output writer; DEPTH must be a power of two so the
// pointers wrap by natural overflow.
module writer_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Storage carries no reset; an empty count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/writer.sv
// Output-side byte writer: buffers router bytes and presents them to the host over a
// 4-phase request/acknowledge handshake on the output pins.
//
//   state   | meaning
//   IDLE    | waiting for a queued byte and a released (low) acknowledge
//   SETUP   | byte driven on pins, request held low for one setup cycle
//   REQ     | request high, byte stable, waiting for acknowledge
//   RELEASE | request low, waiting for the host to drop acknowledge
module writer
  import writer_pkg::*;
#(
  parameter int DATA_W      = WRITER_DATA_W,
  parameter int DEPTH       = WRITER_DEPTH,
  parameter int SYNC_STAGES = WRITER_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] output_byte_in,
  input  logic              output_byte_pulse,
  input  logic              output_acknowledge,
  output logic [DATA_W-1:0] output_byte,
  output logic              output_request,
  output logic              output_ready,
  output logic              overflow_pulse,
  output logic              writer_busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  writer_state_t     state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic              ack_s;
  logic              push, pop, load;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full, empty;
  logic [DATA_W-1:0] byte_q;
  logic              req_q;
  logic              ovf_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ack_sync <= '0;
    else       ack_sync <= {ack_sync[SYNC_STAGES-2:0], output_acknowledge};
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // A full FIFO still takes a write in the cycle its head is being popped.
  assign push = output_byte_pulse && (!full || pop);

  writer_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .din   (output_byte_in),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ack still high means the host has not finished releasing; never start over it.
        if (!empty && !ack_s) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = REQ;
      REQ: begin
        if (ack_s) begin
          pop     = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      byte_q <= '0;
      req_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (load) byte_q <= head;
      req_q <= (state_d == REQ);
      ovf_q <= output_byte_pulse && !push;
    end
  end

  assign output_byte    = byte_q;
  assign output_request = req_q;
  assign overflow_pulse = ovf_q;
  assign output_ready   = (count < DEPTH_CNT);
  assign writer_busy    = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_writer.sv
// Self-checking bench for writer: scoreboard of expected bytes checked at each request rise,
// plus per-scenario cycle-accurate checks.
module tb_writer;
  import writer_pkg::*;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] output_byte_in = 8'h00;
  logic       output_byte_pulse = 1'b0;
  logic       output_acknowledge = 1'b0;
  logic [7:0] output_byte;
  logic       output_request;
  logic       output_ready;
  logic       overflow_pulse;
  logic       writer_busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  bit   host_en = 1'b0;
  int   host_delay = 2;
  int   delivered = 0;
  logic [7:0] held_byte = 8'h00;
  bit   stable_ok = 1'b1;
  bit   prev_req = 1'b0;

  writer #(.DATA_W(8), .DEPTH(2), .SYNC_STAGES(2)) dut (
    .clk                (clk),
    .nrst               (nrst),
    .output_byte_in     (output_byte_in),
    .output_byte_pulse  (output_byte_pulse),
    .output_acknowledge (output_acknowledge),
    .output_byte        (output_byte),
    .output_request     (output_request),
    .output_ready       (output_ready),
    .overflow_pulse     (overflow_pulse),
    .writer_busy        (writer_busy)
  );

  always #5 clk = ~clk;

  // Host model: follows request with ack after host_delay cycles in each phase.
  initial begin
    int hcnt;
    hcnt = 0;
    forever begin
      @(negedge clk);
      if (!host_en) hcnt = 0;
      else if (output_request != output_acknowledge) begin
        if (hcnt >= host_delay) begin
          output_acknowledge = output_request;
          hcnt = 0;
        end else hcnt++;
      end else hcnt = 0;
    end
  end

  // Scoreboard monitor: each request rise must present the oldest expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!nrst) prev_req = 1'b0;
      else begin
        if (output_request && !prev_req) begin
          checks++;
          delivered++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: output_byte=%h presented, expected no byte", output_byte);
          end else begin
            e = exp_q.pop_front();
            if (output_byte !== e) begin
              errors++;
              $display("FAIL sb_order: output_byte=%h expected %h", output_byte, e);
            end
          end
          held_byte = output_byte;
          stable_ok = 1'b1;
        end else if (output_request && output_byte !== held_byte) stable_ok = 1'b0;
        if (!output_request && prev_req) begin
          checks++;
          if (!stable_ok) begin
            errors++;
            $display("FAIL req_stable: output_byte changed during REQ, now %h expected %h", output_byte, held_byte);
          end
        end
        prev_req = output_request;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    output_byte_in = b;
    output_byte_pulse = 1'b1;
    exp_q.push_back(b);
    @(posedge clk); #1;
    output_byte_pulse = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!writer_busy && exp_q.size() == 0 && !output_acknowledge && !output_request) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (output_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", output_byte); end
    checks++; if (output_request !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", output_request); end
    checks++; if (overflow_pulse !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow_pulse); end
    checks++; if (writer_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", writer_busy); end
    checks++; if (output_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", output_ready); end
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  task automatic test_single();
    host_en = 1'b1;
    host_delay = 2;
    @(posedge clk); #1;
    output_byte_in = 8'hA5;
    output_byte_pulse = 1'b1;
    exp_q.push_back(8'hA5);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (output_request !== 1'b0) begin errors++; $display("FAIL single_req_c1: got %b expected 0", output_request); end
      end
      if (k == 2) begin
        checks++; if (output_byte !== 8'hA5) begin errors++; $display("FAIL single_byte_c2: got %h expected a5", output_byte); end
        checks++; if (output_request !== 1'b0) begin errors++; $display("FAIL single_req_c2: got %b expected 0", output_request); end
      end
      if (k == 3) begin
        checks++; if (output_request !== 1'b1) begin errors++; $display("FAIL single_req_c3: got %b expected 1", output_request); end
      end
      if (k == 7) begin
        checks++; if (output_request !== 1'b1) begin errors++; $display("FAIL single_req_c7: got %b expected 1", output_request); end
      end
      if (k == 8) begin
        checks++; if (output_request !== 1'b0) begin errors++; $display("FAIL single_req_fall_c8: got %b expected 0", output_request); end
      end
      if (k == 12) begin
        checks++; if (writer_busy !== 1'b1) begin errors++; $display("FAIL single_busy_c12: got %b expected 1", writer_busy); end
      end
      if (k == 13) begin
        checks++; if (writer_busy !== 1'b0) begin errors++; $display("FAIL single_busy_c13: got %b expected 0", writer_busy); end
      end
      if (k == 0) begin
        @(posedge clk); #1;
        output_byte_pulse = 1'b0;
      end
    end
  endtask

  task automatic test_burst();
    bit to;
    host_en = 1'b0;
    output_acknowledge = 1'b0;
    @(posedge clk); #1;
    output_byte_in = 8'h11; output_byte_pulse = 1'b1; exp_q.push_back(8'h11);
    @(posedge clk); #1;
    output_byte_in = 8'h22; exp_q.push_back(8'h22);
    @(posedge clk); #1;
    checks++; if (output_ready !== 1'b0) begin errors++; $display("FAIL burst_ready: got %b expected 0", output_ready); end
    output_byte_in = 8'h33;
    @(negedge clk);
    checks++; if (overflow_pulse !== 1'b0) begin errors++; $display("FAIL burst_ovf_c2: got %b expected 0", overflow_pulse); end
    @(posedge clk); #1;
    output_byte_pulse = 1'b0;
    @(negedge clk);
    checks++; if (overflow_pulse !== 1'b1) begin errors++; $display("FAIL burst_ovf_c3: got %b expected 1", overflow_pulse); end
    @(negedge clk);
    checks++; if (overflow_pulse !== 1'b0) begin errors++; $display("FAIL burst_ovf_c4: got %b expected 0", overflow_pulse); end
    repeat (4) @(negedge clk);
    host_en = 1'b1;
    wait_drain(200, to);
    checks++; if (to) begin errors++; $display("FAIL burst_drain: timed out with %0d bytes pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_simul();
    bit to;
    bit seen;
    host_en = 1'b0;
    output_acknowledge = 1'b0;
    @(posedge clk); #1;
    output_byte_in = 8'h61; output_byte_pulse = 1'b1; exp_q.push_back(8'h61);
    @(posedge clk); #1;
    output_byte_in = 8'h62; exp_q.push_back(8'h62);
    @(posedge clk); #1;
    output_byte_pulse = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (output_request) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL simul_req: request=%b expected 1 within 10 cycles", output_request); end
    output_acknowledge = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (output_ready !== 1'b0) begin errors++; $display("FAIL simul_ready_pre: got %b expected 0", output_ready); end
    output_byte_in = 8'h44; output_byte_pulse = 1'b1; exp_q.push_back(8'h44);
    @(posedge clk); #1;
    output_byte_pulse = 1'b0;
    @(negedge clk);
    checks++; if (overflow_pulse !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b expected 0", overflow_pulse); end
    checks++; if (output_request !== 1'b0) begin errors++; $display("FAIL simul_req_fall: got %b expected 0", output_request); end
    checks++; if (output_ready !== 1'b0) begin errors++; $display("FAIL simul_ready_post: got %b expected 0", output_ready); end
    host_en = 1'b1;
    wait_drain(300, to);
    checks++; if (to) begin errors++; $display("FAIL simul_drain: timed out with %0d bytes pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_ack_at_reset();
    bit to;
    bit req_seen;
    host_en = 1'b0;
    output_acknowledge = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (4) @(posedge clk);
    send(8'h5A);
    req_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (output_request) req_seen = 1'b1;
    end
    checks++; if (req_seen) begin errors++; $display("FAIL ackrst_hold: request=1 seen, expected 0 while ack high"); end
    checks++; if (writer_busy !== 1'b1) begin errors++; $display("FAIL ackrst_busy: got %b expected 1", writer_busy); end
    output_acknowledge = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) begin
        checks++; if (output_request !== 1'b0) begin errors++; $display("FAIL ackrst_req_t3: got %b expected 0", output_request); end
      end
      if (k == 4) begin
        checks++; if (output_request !== 1'b1) begin errors++; $display("FAIL ackrst_req_t4: got %b expected 1", output_request); end
      end
    end
    host_en = 1'b1;
    wait_drain(200, to);
    checks++; if (to) begin errors++; $display("FAIL ackrst_drain: timed out with %0d bytes pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit req_seen;
    host_en = 1'b0;
    output_acknowledge = 1'b0;
    @(posedge clk); #1;
    output_byte_in = 8'h71; output_byte_pulse = 1'b1; exp_q.push_back(8'h71);
    @(posedge clk); #1;
    output_byte_in = 8'h72; exp_q.push_back(8'h72);
    @(posedge clk); #1;
    output_byte_pulse = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (output_request) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_req: request=%b expected 1 within 10 cycles", output_request); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (output_request !== 1'b0) begin errors++; $display("FAIL rstmid_req_now: got %b expected 0", output_request); end
    checks++; if (output_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte_now: got %h expected 00", output_byte); end
    checks++; if (writer_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_now: got %b expected 0", writer_busy); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    host_en = 1'b1;
    req_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (output_request) req_seen = 1'b1;
    end
    checks++; if (req_seen) begin errors++; $display("FAIL rstmid_stale: request=1 seen after reset, expected 0"); end
    checks++; if (writer_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b expected 0", writer_busy); end
  endtask

  task automatic test_wrap();
    bit to;
    bit ready_seen;
    int base;
    host_en = 1'b1;
    host_delay = 1;
    base = delivered;
    for (int i = 0; i < 10; i++) begin
      ready_seen = 1'b0;
      for (int w = 0; w < 50; w++) begin
        @(posedge clk); #1;
        if (output_ready) begin ready_seen = 1'b1; break; end
      end
      checks++; if (!ready_seen) begin errors++; $display("FAIL wrap_ready_%0d: ready=%b expected 1 within 50 cycles", i, output_ready); end
      output_byte_in = 8'(i);
      output_byte_pulse = 1'b1;
      exp_q.push_back(8'(i));
      @(posedge clk); #1;
      output_byte_pulse = 1'b0;
    end
    wait_drain(400, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_drain: timed out with %0d bytes pending, expected 0", exp_q.size()); end
    checks++; if (delivered - base != 10) begin errors++; $display("FAIL wrap_count: delivered %0d bytes expected 10", delivered - base); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simul();
    test_ack_at_reset();
    test_reset_mid();
    test_wrap();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: %0d bytes pending expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/writer.md
Name: writer

Overview:
- Output-side counterpart of the input handshake block.
- Accepts single-cycle byte pulses from the data router (cipher output) and buffers them in a small FIFO.
- Presents each byte on the chip output pins using a 4-phase request/acknowledge handshake with the external host.
- Synchronises the asynchronous output_acknowledge pin; owns the output_request pin.

Parameters:
- DATA_W, 8: width of each output byte.
- DEPTH, 2: FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: flop stages on output_acknowledge; at least 2.

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- output_byte_in  input  DATA_W  byte from data router; sampled only when output_byte_pulse=1.
- output_byte_pulse  input  1  single-cycle write strobe.
- output_acknowledge  input  1  host acknowledge pin; asynchronous to clk.
- output_byte  output  DATA_W  byte driven to pins.
- output_request  output  1  4-phase request to host.
- output_ready  output  1  FIFO not full (count < DEPTH); combinational from count.
- overflow_pulse  output  1  one-cycle pulse when a write is dropped.
- writer_busy  output  1  FIFO non-empty or state != IDLE.

Behaviour:
- Reset (async, nrst=0):
  - FIFO emptied; state IDLE.
  - Sync chain cleared to 0.
  - output_byte=0, output_request=0, overflow_pulse=0.
  - Outputs take these values immediately, without waiting for a clock edge.
- Acknowledge synchroniser: ack_s is output_acknowledge delayed through SYNC_STAGES flops. The FSM uses only ack_s.
- FIFO:
  - Circular buffer with wrapping pointers and a count of width clog2(DEPTH)+1.
  - Push happens when output_byte_pulse=1 and the FIFO accepts the write.
  - Pop happens on the REQ->RELEASE transition.
  - Write accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - A rejected write discards the data and raises overflow_pulse on the next cycle.
  - Push and pop in the same cycle leave count unchanged.
- FSM, registered, state type writer_state_t:
  - IDLE: when count>0 and ack_s==0, latch the FIFO head into output_byte and go to SETUP. If ack_s==1, stay in IDLE; this covers a host still releasing the previous transfer or after reset.
  - SETUP: hold output_request=0 for one cycle for data setup, then go to REQ.
  - REQ: output_request=1 and output_byte held stable. When ack_s==1, pop the FIFO and go to RELEASE.
  - RELEASE: output_request=0 and output_byte held. When ack_s==0, go to IDLE.
- output_request is a registered decode of the state: 1 only in REQ.
- output_byte changes only on the IDLE->SETUP transition.
- Latency (idle, empty FIFO, ack low):
  - Pulse in cycle 0, count=1 in cycle 1.
  - SETUP in cycle 2, output_byte valid from cycle 2.
  - output_request=1 from cycle 3.
- After ack rises, output_request falls SYNC_STAGES+1 cycles later.
- Minimum per-byte turnaround with an instant host is 2*SYNC_STAGES+4 cycles.
- Bytes leave in strict FIFO order; no byte is duplicated or lost except by overflow.
- A glitch on ack shorter than one clock may be missed; the host must hold each phase for at least SYNC_STAGES+1 clocks.
- Reset mid-handshake: output_request drops immediately. After reset, the first new request waits for ack_s==0.

Decomposition:
- Shared package entries:
  - writer_state_t enum {IDLE, SETUP, REQ, RELEASE}.
  - Default constants for DATA_W, DEPTH and SYNC_STAGES, alongside the existing interface_state_t.
- One natural sub-module: writer_fifo, a parameterised circular buffer with push, pop, head, count, full and empty.
- The synchroniser and FSM stay in writer.

Test Plan:
- Single byte: pulse 0xA5 in cycle 0 with the host acking 2 cycles after each request edge.
  - output_byte=0xA5 from cycle 2 and output_request rises in cycle 3.
  - Request falls 3 cycles after ack rises.
  - writer_busy=0 after ack falls and syncs.
- Burst of three with DEPTH=2 and host stalled (ack held 0): pulses 0x11, 0x22, 0x33 in consecutive cycles.
  - 0x11 and 0x22 are accepted.
  - For 0x33, output_ready=0 beforehand and overflow_pulse=1 one cycle after its strobe.
  - Releasing the host yields 0x11 then 0x22 only.
- Simultaneous push and pop: FIFO full, pulse 0x44 in the exact cycle of the REQ->RELEASE transition.
  - Write accepted with no overflow; output order continues with 0x44 last.
- Ack already high at reset release: the FIFO holds 0x5A.
  - output_request stays 0 until ack low has been synchronised, then the normal SETUP/REQ sequence follows.
- Reset mid-REQ: assert nrst=0 while output_request=1 with 2 entries queued.
  - output_request=0 and output_byte=0 immediately; after release, writer_busy=0 and no stale byte is presented.
- Wrap-around: 10 bytes 0x00..0x09, each with a full handshake.
  - All appear in order across pointer wrap, and every output_byte stays stable for the entire REQ phase.
